// File: rtl/host_bridge_pkg.sv
// Shared constants and helpers for the host bridge.
// The address window check is only used when HOST_BRIDGE_ADDR_CHECK_EN is defined.
package host_bridge_pkg;

  localparam logic [15:0] PUTCHAR_OFFSET = 16'h1000;
  localparam logic [15:0] FINISH_OFFSET  = 16'h2000;
  localparam logic [15:0] WINDOW_MASK    = 16'hFFFF;

  function automatic logic addr_in_window(input logic [15:0] offset);
    return ((offset & WINDOW_MASK) == PUTCHAR_OFFSET) ||
           ((offset & WINDOW_MASK) == FINISH_OFFSET);
  endfunction

endpackage

// File: rtl/host_bridge_fifo.sv
// Synchronous FIFO with asynchronous active-low reset.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module host_bridge_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]      r_wptr;
  logic [PtrW:0]      r_rptr;
  logic [Width-1:0]   r_mem [Depth];
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                   (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr[PtrW-1:0]];

  // Storage is cleared too, so the head reads as zero while in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[PtrW-1:0]] <= i_data;
        r_wptr                  <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/host_bridge.sv
// Bridges valid/ready memory requests onto a single-cycle host strobe with in-order responses.
// Define HOST_BRIDGE_ADDR_CHECK_EN to reject requests outside the putchar/finish window.
module host_bridge
  import host_bridge_pkg::*;
#(
  parameter int unsigned addr_width_p   = 32,
  parameter int unsigned data_width_p   = 64,
  parameter int unsigned id_width_p     = 4,
  parameter int unsigned depth_p        = 4,
  localparam int unsigned mask_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [addr_width_p-1:0]  req_addr_i,
  input  logic [data_width_p-1:0]  req_data_i,
  input  logic [mask_width_lp-1:0] req_be_i,
  input  logic [id_width_p-1:0]    req_id_i,
  output logic                     rsp_v_o,
  input  logic                     rsp_ready_i,
  output logic [data_width_p-1:0]  rsp_data_o,
  output logic [id_width_p-1:0]    rsp_id_o,
  output logic                     rsp_err_o,
  output logic                     host_req_o,
  output logic                     host_we_o,
  output logic [addr_width_p-1:0]  host_addr_o,
  output logic [data_width_p-1:0]  host_data_o,
  output logic [mask_width_lp-1:0] host_be_o,
  input  logic [data_width_p-1:0]  host_data_i
);

  typedef struct packed {
    logic                     we;
    logic [addr_width_p-1:0]  addr;
    logic [data_width_p-1:0]  data;
    logic [mask_width_lp-1:0] be;
    logic [id_width_p-1:0]    id;
  } req_t;

`ifdef HOST_BRIDGE_ADDR_CHECK_EN
  typedef struct packed {
    logic                    err;
    logic [id_width_p-1:0]   id;
    logic [data_width_p-1:0] data;
  } rsp_t;
`else
  typedef struct packed {
    logic [id_width_p-1:0]   id;
    logic [data_width_p-1:0] data;
  } rsp_t;
`endif

  localparam int unsigned CntW = $clog2(depth_p + 1);

  logic [CntW-1:0]          r_cnt;
  logic                     r_live;
  logic                     r_issue_v;
  logic                     r_issue_err;
  logic [id_width_p-1:0]    r_issue_id;
  logic                     r_host_req;
  logic                     r_host_we;
  logic [addr_width_p-1:0]  r_host_addr;
  logic [data_width_p-1:0]  r_host_data;
  logic [mask_width_lp-1:0] r_host_be;

  logic w_req_hs;
  logic w_rsp_hs;
  logic w_reqf_empty;
  logic w_rspf_empty;
  logic w_issue_v;
  logic w_issue_err;
  req_t w_req_in;
  req_t w_reqf_head;
  req_t w_issue;
  rsp_t w_rsp_in;
  rsp_t w_rsp_head;

  // r_live keeps ready low while reset is asserted even though r_cnt reads zero.
  assign req_ready_o = r_live && (r_cnt < CntW'(depth_p));
  assign w_req_hs    = req_v_i & req_ready_o;
  assign w_rsp_hs    = rsp_v_o & rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case ({w_req_hs, w_rsp_hs})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_req_in = '{we: req_we_i, addr: req_addr_i, data: req_data_i,
                      be: req_be_i, id: req_id_i};

  // An empty FIFO is bypassed so a fresh request reaches the host on the next cycle.
  assign w_issue_v = w_req_hs | ~w_reqf_empty;
  assign w_issue   = w_reqf_empty ? w_req_in : w_reqf_head;

`ifdef HOST_BRIDGE_ADDR_CHECK_EN
  assign w_issue_err = ~addr_in_window(w_issue.addr[15:0]);
`else
  assign w_issue_err = 1'b0;
`endif

  host_bridge_fifo #(
    .Width ($bits(req_t)),
    .Depth (depth_p)
  ) u_req_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_req_hs & ~w_reqf_empty),
    .i_data  (w_req_in),
    .i_pop   (~w_reqf_empty),
    .o_data  (w_reqf_head),
    .o_empty (w_reqf_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issue_v   <= 1'b0;
      r_issue_err <= 1'b0;
      r_issue_id  <= '0;
      r_host_req  <= 1'b0;
      r_host_we   <= 1'b0;
      r_host_addr <= '0;
      r_host_data <= '0;
      r_host_be   <= '0;
    end else begin
      r_issue_v   <= w_issue_v;
      r_issue_err <= w_issue_v & w_issue_err;
      r_host_req  <= w_issue_v & ~w_issue_err;
      if (w_issue_v) begin
        r_issue_id  <= w_issue.id;
        r_host_we   <= w_issue.we;
        r_host_addr <= w_issue.addr;
        r_host_data <= w_issue.data;
        r_host_be   <= w_issue.be;
      end
    end
  end

  assign host_req_o  = r_host_req;
  assign host_we_o   = r_host_we;
  assign host_addr_o = r_host_addr;
  assign host_data_o = r_host_data;
  assign host_be_o   = r_host_be;

  // Error slots take the same path as real issues so ordering and latency match.
`ifdef HOST_BRIDGE_ADDR_CHECK_EN
  assign w_rsp_in = '{err: r_issue_err, id: r_issue_id,
                      data: (r_host_we | r_issue_err) ? '0 : host_data_i};
`else
  assign w_rsp_in = '{id: r_issue_id,
                      data: (r_host_we | r_issue_err) ? '0 : host_data_i};
`endif

  host_bridge_fifo #(
    .Width ($bits(rsp_t)),
    .Depth (depth_p)
  ) u_rsp_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (r_issue_v),
    .i_data  (w_rsp_in),
    .i_pop   (w_rsp_hs),
    .o_data  (w_rsp_head),
    .o_empty (w_rspf_empty)
  );

  assign rsp_v_o    = ~w_rspf_empty;
  assign rsp_data_o = w_rsp_head.data;
  assign rsp_id_o   = w_rsp_head.id;
`ifdef HOST_BRIDGE_ADDR_CHECK_EN
  assign rsp_err_o  = w_rsp_head.err;
`else
  assign rsp_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_host_bridge.sv
// Self-checking bench for host_bridge: vector table, timing sequences and a randomized
// run against a queue-based reference model.
module tb_host_bridge;

`ifdef HOST_BRIDGE_ADDR_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif
  localparam int Depth = 4;
  localparam int NRnd  = 1500;

  logic        clk;
  logic        rst_n;
  logic        req_v;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_be;
  logic [3:0]  req_id;
  logic        rsp_v;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_id;
  logic        rsp_err;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [63:0] host_wdata;
  logic [7:0]  host_be;
  logic [63:0] host_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  host_bridge dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_v_i     (req_v),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_be_i    (req_be),
    .req_id_i    (req_id),
    .rsp_v_o     (rsp_v),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_err_o   (rsp_err),
    .host_req_o  (host_req),
    .host_we_o   (host_we),
    .host_addr_o (host_addr),
    .host_data_o (host_wdata),
    .host_be_o   (host_be),
    .host_data_i (host_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return ChkEn && !(a[15:0] == 16'h1000 || a[15:0] == 16'h2000);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [3:0]  id;
    logic [63:0] hdata;
    logic        exp_hreq;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [6];

  // Reference model state for the randomized run
  logic        m_we    [4096];
  logic [31:0] m_addr  [4096];
  logic [63:0] m_wdata [4096];
  logic [7:0]  m_be    [4096];
  logic [3:0]  m_id    [4096];
  logic        m_err   [4096];
  logic        m_known [4096];
  logic [63:0] m_rdata [4096];
  int          iss     [4096];

  initial begin
    int nid;
    int nrsp;
    int mh;
    int mt;
    int ih;
    int it;
    int j;
    int sel;

    tbl[0] = '{1'b1, 32'h0000_1000, 64'h41, 8'h01, 4'd3, 64'hFFFF_FFFF, 1'b1, 64'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_1000, 64'h0, 8'hFF, 4'd5, 64'hDEAD_BEEF, 1'b1, 64'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_2000, 64'h0, 8'hF0, 4'd15, 64'h0123_4567_89AB_CDEF, 1'b1,
               64'h0123_4567_89AB_CDEF, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_3000, 64'h55, 8'hFF, 4'd7, 64'h1234, !ChkEn, 64'h0, ChkEn};
    tbl[4] = '{1'b0, 32'hABCD_1000, 64'h0, 8'h0F, 4'd2, 64'hCAFE_F00D_0000_0001, 1'b1,
               64'hCAFE_F00D_0000_0001, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_1004, 64'h0, 8'hFF, 4'd9, 64'h77, !ChkEn,
               ChkEn ? 64'h0 : 64'h77, ChkEn};

    rst_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
    req_be = '0; req_id = '0; rsp_ready = 1'b0; host_rdata = '0;

    // Reset state
    #12;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_v", 64'(rsp_v), 64'(0));
    check("rst_host_req", 64'(host_req), 64'(0));
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_host_addr", 64'(host_addr), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'(1));

    // Vector table: isolated transactions with exact N+1 / N+2 timing
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_v = 1'b1; req_we = tbl[i].we; req_addr = tbl[i].addr; req_data = tbl[i].data;
      req_be = tbl[i].be; req_id = tbl[i].id; host_rdata = tbl[i].hdata; rsp_ready = 1'b1;
      @(negedge clk);
      check("tbl_ready", 64'(req_ready), 64'(1));
      @(posedge clk); #1;
      req_v = 1'b0;
      @(negedge clk);
      check("tbl_host_req", 64'(host_req), 64'(tbl[i].exp_hreq));
      if (tbl[i].exp_hreq) begin
        check("tbl_host_we", 64'(host_we), 64'(tbl[i].we));
        check("tbl_host_addr", 64'(host_addr), 64'(tbl[i].addr));
        check("tbl_host_data", host_wdata, tbl[i].data);
        check("tbl_host_be", 64'(host_be), 64'(tbl[i].be));
      end
      check("tbl_rsp_early", 64'(rsp_v), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check("tbl_host_req_once", 64'(host_req), 64'(0));
      check("tbl_rsp_v", 64'(rsp_v), 64'(1));
      check("tbl_rsp_data", rsp_data, tbl[i].exp_data);
      check("tbl_rsp_id", 64'(rsp_id), 64'(tbl[i].id));
      check("tbl_rsp_err", 64'(rsp_err), 64'(tbl[i].exp_err));
      @(posedge clk); #1;
      @(negedge clk);
      check("tbl_rsp_done", 64'(rsp_v), 64'(0));
    end

    // Back-to-back writes: one issue and one response per cycle, no gaps
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        req_v = 1'b1; req_we = 1'b1; req_addr = 32'h1000; req_be = 8'hFF;
        req_data = 64'(c) + 64'h100; req_id = 4'(c);
      end else begin
        req_v = 1'b0;
      end
      @(negedge clk);
      if (c < 8) check("b2b_ready", 64'(req_ready), 64'(1));
      check("b2b_host_req", 64'(host_req), 64'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) check("b2b_host_data", host_wdata, 64'(c - 1) + 64'h100);
      check("b2b_rsp_v", 64'(rsp_v), 64'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) check("b2b_rsp_id", 64'(rsp_id), 64'(c - 2));
    end

    // Backpressure: 4 accepted while stalled, full+pop cycle, then the rest drain in order
    nid = 0; nrsp = 0;
    for (int c = 0; c < 40 && nrsp < 6; c++) begin
      @(posedge clk); #1;
      rsp_ready = (c >= 8);
      req_v = (nid < 6); req_we = 1'b1; req_addr = 32'h2000;
      req_data = 64'(nid); req_id = 4'(nid);
      @(negedge clk);
      if (c == 5) begin
        check("bp_hold_v", 64'(rsp_v), 64'(1));
        check("bp_hold_id", 64'(rsp_id), 64'(0));
      end
      if (c == 7) begin
        check("bp_accepted", 64'(nid), 64'(4));
        check("bp_stall", 64'(req_ready), 64'(0));
      end
      if (c == 8) check("bp_full_pop_same_cycle", 64'(req_ready), 64'(0));
      if (c == 9) check("bp_ready_after_pop", 64'(req_ready), 64'(1));
      if (rsp_v && rsp_ready) begin
        check("bp_rsp_order", 64'(rsp_id), 64'(nrsp));
        nrsp++;
      end
      if (req_v && req_ready) nid++;
    end
    check("bp_all_accepted", 64'(nid), 64'(6));
    check("bp_all_rsp", 64'(nrsp), 64'(6));

    // Reset mid-operation with three reads outstanding
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_v = 1'b1; req_we = 1'b0; req_addr = 32'h1000; req_data = 64'hAA;
      req_be = 8'hFF; req_id = 4'(5 + k); host_rdata = 64'h1111_0000 + 64'(k);
      @(posedge clk); #1;
    end
    req_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_pre_rsp_v", 64'(rsp_v), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    check("mid_rst_rsp_v", 64'(rsp_v), 64'(0));
    check("mid_rst_host_req", 64'(host_req), 64'(0));
    check("mid_rst_rsp_data", rsp_data, 64'h0);
    check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
    check("mid_rst_host_addr", 64'(host_addr), 64'h0);
    check("mid_rst_host_data", host_wdata, 64'h0);
    check("mid_rst_host_be", 64'(host_be), 64'(0));
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("mid_post_ready", 64'(req_ready), 64'(1));
    for (int k = 0; k < 3; k++) begin
      check("mid_no_stale_rsp", 64'(rsp_v), 64'(0));
      check("mid_no_stale_host", 64'(host_req), 64'(0));
      @(negedge clk);
    end

    // Randomized traffic against the reference model
    mh = 0; mt = 0; ih = 0; it = 0;
    for (int cyc = 0; cyc < NRnd + 300; cyc++) begin
      if (cyc >= NRnd && mh == mt) break;
      @(posedge clk); #1;
      sel = int'($urandom_range(3));
      req_v = (cyc < NRnd) && ($urandom_range(3) != 0);
      req_we = 1'($urandom);
      req_addr = (sel == 0) ? {16'($urandom), 16'h1000} :
                 (sel == 1) ? {16'($urandom), 16'h2000} :
                 (sel == 2) ? {16'($urandom), 16'h3000} : $urandom;
      req_data = {$urandom, $urandom};
      req_be = 8'($urandom);
      req_id = 4'($urandom);
      rsp_ready = (cyc >= NRnd) || ($urandom_range(9) < 7);
      host_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("rnd_ready", 64'(req_ready), 64'((mt - mh) < Depth));
      if (host_req) begin
        check("rnd_issue_pending", 64'(it > ih), 64'(1));
        if (it > ih) begin
          j = iss[ih];
          check("rnd_host_we", 64'(host_we), 64'(m_we[j]));
          check("rnd_host_addr", 64'(host_addr), 64'(m_addr[j]));
          check("rnd_host_data", host_wdata, m_wdata[j]);
          check("rnd_host_be", 64'(host_be), 64'(m_be[j]));
          if (!m_we[j]) m_rdata[j] = host_rdata;
          m_known[j] = 1'b1;
          ih++;
        end
      end
      if (rsp_v && rsp_ready) begin
        check("rnd_rsp_pending", 64'(mt > mh), 64'(1));
        if (mt > mh) begin
          check("rnd_rsp_known", 64'(m_known[mh]), 64'(1));
          check("rnd_rsp_id", 64'(rsp_id), 64'(m_id[mh]));
          check("rnd_rsp_data", rsp_data, m_rdata[mh]);
          check("rnd_rsp_err", 64'(rsp_err), 64'(m_err[mh]));
          mh++;
        end
      end
      if (req_v && req_ready) begin
        m_we[mt] = req_we; m_addr[mt] = req_addr; m_wdata[mt] = req_data;
        m_be[mt] = req_be; m_id[mt] = req_id; m_err[mt] = is_err(req_addr);
        m_rdata[mt] = 64'h0;
        m_known[mt] = m_err[mt] || req_we;
        if (!m_err[mt]) begin
          iss[it] = mt;
          it++;
        end
        mt++;
      end
    end
    check("rnd_drained", 64'(mh == mt), 64'(1));
    check("rnd_all_issued", 64'(ih == it), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
